// File: rtl/nand4_x2_pkg.sv
// Shared constants and helpers for the registered NAND4 cell and its
// optional activity counter.
package nand4_x2_pkg;

  localparam int   CNT_W_DEF = 16;
  localparam logic ZN_RST    = 1'b1;

  // Saturating +1 on a counter of width w (w <= 32); holds at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (cnt >= max_v) ? max_v : (cnt + 32'd1);
  endfunction

endpackage

// File: rtl/nand4_lane.sv
// One registered NAND4 bit with synchronous active-high reset to ZN_RST.
module nand4_lane
  import nand4_x2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic a4,
  output logic zn
);

  logic zn_d;
  logic zn_q;

  always_comb begin
    zn_d = ~(a1 & a2 & a3 & a4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zn_q <= ZN_RST;
    end else begin
      zn_q <= zn_d;
    end
  end

  assign zn = zn_q;

endmodule

// File: rtl/nand4_x2.sv
// Registered NAND4, WIDTH independent lanes, with an optional saturating
// output-activity counter compiled in by defining NAND4_X2_ACT_CNT_EN.
module nand4_x2
  import nand4_x2_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  output logic [WIDTH-1:0] zn,
  output logic [CNT_W-1:0] act_cnt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    nand4_lane u_lane (
      .clk (clk),
      .rst (rst),
      .a1  (a1[i]),
      .a2  (a2[i]),
      .a3  (a3[i]),
      .a4  (a4[i]),
      .zn  (zn[i])
    );
  end

`ifdef NAND4_X2_ACT_CNT_EN
  logic [WIDTH-1:0] zn_nxt;
  logic             zn_chg;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Compare the value the lanes are about to load against what they hold now.
  always_comb begin
    zn_nxt = ~(a1 & a2 & a3 & a4);
    zn_chg = |(zn_nxt ^ zn);
    cnt_d  = cnt_q;
    if (rst) begin
      cnt_d = '0;
    end else if (zn_chg) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), unsigned'(CNT_W)));
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign act_cnt = cnt_q;
`else
  assign act_cnt = '0;
`endif

endmodule

// File: tb/tb_nand4_x2.sv
// Bench for nand4_x2: three instances (1 lane/16-bit count, 4 lanes/16-bit
// count, 1 lane/2-bit count) driven together and compared to a lane model.
module tb_nand4_x2;

`ifdef NAND4_X2_ACT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a1, a2, a3, a4;
  logic        zn0;
  logic [15:0] cnt0;
  logic [3:0]  zn1;
  logic [15:0] cnt1;
  logic        zn2;
  logic [1:0]  cnt2;

  int checks   = 0;
  int failures = 0;

  // Reference state per instance: registered output and activity count.
  int m_zn  [3];
  int m_cnt [3];
  int m_w   [3] = '{1, 4, 1};
  int m_max [3] = '{65535, 65535, 3};

  always #5 clk = ~clk;

  nand4_x2 #(.WIDTH(1), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .a1(a1[0]), .a2(a2[0]), .a3(a3[0]), .a4(a4[0]),
    .zn(zn0), .act_cnt(cnt0));

  nand4_x2 #(.WIDTH(4), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .zn(zn1), .act_cnt(cnt1));

  nand4_x2 #(.WIDTH(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .a1(a1[0]), .a2(a2[0]), .a3(a3[0]), .a4(a4[0]),
    .zn(zn2), .act_cnt(cnt2));

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A lane outputs 0 only when all four of its operands are 1.
  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      int nz;
      nz = 0;
      for (int i = 0; i < m_w[d]; i++) begin
        int ones;
        ones = int'(a1[i]) + int'(a2[i]) + int'(a3[i]) + int'(a4[i]);
        if (ones != 4) nz += (1 << i);
      end
      if (rst) begin
        m_zn[d]  = (1 << m_w[d]) - 1;
        m_cnt[d] = 0;
      end else begin
        if (nz != m_zn[d] && m_cnt[d] < m_max[d]) m_cnt[d]++;
        m_zn[d] = nz;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  function automatic int exp_cnt(input int d);
    return CNT_EN ? m_cnt[d] : 0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".zn0"},  32'(zn0),  32'(m_zn[0]));
    check({tag, ".cnt0"}, 32'(cnt0), 32'(exp_cnt(0)));
    check({tag, ".zn1"},  32'(zn1),  32'(m_zn[1]));
    check({tag, ".cnt1"}, 32'(cnt1), 32'(exp_cnt(1)));
    check({tag, ".zn2"},  32'(zn2),  32'(m_zn[2]));
    check({tag, ".cnt2"}, 32'(cnt2), 32'(exp_cnt(2)));
  endtask

  task automatic set_all(input logic [3:0] v);
    a1 = {4{v[3]}};
    a2 = {4{v[2]}};
    a3 = {4{v[1]}};
    a4 = {4{v[0]}};
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      m_zn[d]  = 0;
      m_cnt[d] = 0;
    end
    rst = 1'b1;
    set_all(4'b0000);
    step();
    step();
    check_all("reset");
    check("reset.zn1_ones", 32'(zn1), 32'hF);
    check("reset.cnt0_zero", 32'(cnt0), 32'h0);
    rst = 1'b0;

    // Exhaustive truth table, a1 as MSB.
    for (int v = 0; v < 16; v++) begin
      logic [3:0] vv;
      vv = 4'(v);
      set_all(vv);
      step();
      check($sformatf("sweep%0d.zn0", v), 32'(zn0), (v == 15) ? 32'h0 : 32'h1);
      check_all($sformatf("sweep%0d", v));
    end

    // Reset while output is 0 and inputs are all ones.
    rst = 1'b1;
    step();
    check("rst_mid.zn0", 32'(zn0), 32'h1);
    check("rst_mid.cnt0", 32'(cnt0), 32'h0);
    rst = 1'b0;
    step();
    check("rst_rel.zn0", 32'(zn0), 32'h0);
    check("rst_rel.cnt0", 32'(cnt0), CNT_EN ? 32'h1 : 32'h0);
    check_all("rst_rel");

    // Lane independence on the 4-lane instance.
    a1 = 4'hF; a2 = 4'hF; a3 = 4'hF; a4 = 4'b1010;
    step();
    check("lanes_a.zn1", 32'(zn1), 32'(4'b0101));
    a4 = 4'b0101;
    step();
    check("lanes_b.zn1", 32'(zn1), 32'(4'b1010));
    check_all("lanes");

    // Counter: 10 toggles from reset, then hold, then saturate the 2-bit one.
    rst = 1'b1;
    set_all(4'b0000);
    step();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      set_all((k % 2 == 0) ? 4'b1111 : 4'b0000);
      step();
    end
    check("toggle10.cnt0", 32'(cnt0), CNT_EN ? 32'd10 : 32'd0);
    check("toggle10.cnt2", 32'(cnt2), CNT_EN ? 32'd3 : 32'd0);
    check_all("toggle10");
    set_all(4'b0000);
    for (int k = 0; k < 5; k++) step();
    check("hold5.cnt0", 32'(cnt0), CNT_EN ? 32'd10 : 32'd0);
    check("hold5.zn0", 32'(zn0), 32'h1);
    for (int k = 0; k < 4; k++) begin
      set_all((k % 2 == 0) ? 4'b1111 : 4'b0000);
      step();
    end
    check("sat.cnt2", 32'(cnt2), CNT_EN ? 32'd3 : 32'd0);
    check("sat.cnt0", 32'(cnt0), CNT_EN ? 32'd14 : 32'd0);
    check_all("sat");

    // Randomised traffic, biased so that all-ones lanes appear often.
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 29) == 0);
      a1 = 4'($urandom) | (($urandom_range(0, 1) == 1) ? 4'hF : 4'h0);
      a2 = 4'($urandom) | (($urandom_range(0, 1) == 1) ? 4'hF : 4'h0);
      a3 = 4'($urandom) | (($urandom_range(0, 1) == 1) ? 4'hF : 4'h0);
      a4 = 4'($urandom) | (($urandom_range(0, 2) != 0) ? 4'hF : 4'h0);
      step();
      check_all($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
